rotor_stage: RTL and testbench

Position and ring-setting stage wrapped around one rotor's fixed wiring permutation in the Enigma M3 datapath. It holds the rotor position counter and ring setting, and generates stepping and notch carry for the next rotor. It rotates one-hot 26-bit letter vectors from the stator frame into the rotor frame on the way into the wiring filter, and back out afterwards, in both the forward and the inverse (return) directions. The exit side is registered, so the stage adds one cycle of latency per direction.

---
 rtl/rotor_stage_if.sv | 30 +++
 rtl/rotor_stage.sv | 90 +++++++++
 tb/tb_rotor_stage.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rotor_stage_if.sv
// Letter datapath bundle between the rotor stage, its controller and the wiring filter.
// Valid-only: no ready/backpressure; a letter is accepted on every edge where its valid is high.
interface rotor_stage_if;
  logic [25:0] fwd_in;
  logic        fwd_valid_in;
  logic [25:0] fwd_to_filt;
  logic [25:0] fwd_from_filt;
  logic [25:0] fwd_out;
  logic        fwd_valid_out;
  logic [25:0] inv_in;
  logic        inv_valid_in;
  logic [25:0] inv_to_filt;
  logic [25:0] inv_from_filt;
  logic [25:0] inv_out;
  logic        inv_valid_out;

  modport master (
    output fwd_in, fwd_valid_in, fwd_from_filt,
    output inv_in, inv_valid_in, inv_from_filt,
    input  fwd_to_filt, fwd_out, fwd_valid_out,
    input  inv_to_filt, inv_out, inv_valid_out
  );

  modport slave (
    input  fwd_in, fwd_valid_in, fwd_from_filt,
    input  inv_in, inv_valid_in, inv_from_filt,
    output fwd_to_filt, fwd_out, fwd_valid_out,
    output inv_to_filt, inv_out, inv_valid_out
  );
endinterface

// File: rtl/rotor_stage.sv
// Enigma rotor position/ring stage: stepping, notch carry, and frame rotation
// of one-hot letters into and out of the rotor's fixed wiring filter.
module rotor_stage #(
  parameter int unsigned NOTCH       = 16,
  parameter bit          ALWAYS_STEP = 1'b0,
  parameter bit          DOUBLE_STEP = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  input  logic          carry_in,
  input  logic          load,
  input  logic [4:0]    load_pos,
  input  logic [4:0]    load_ring,
  rotor_stage_if.slave  bus,
  output logic [4:0]    pos,
  output logic          carry_out
);

  localparam logic [4:0] NOTCH_POS = NOTCH[4:0];

  logic [4:0] ring;
  logic [4:0] off;
  logic [4:0] pos_nxt;
  logic [4:0] ring_nxt;
  logic [4:0] off_nxt;
  logic [5:0] diff;
  logic [5:0] diff_mod;
  logic       at_notch;
  logic       step_en;

  // bit j of the result takes bit (j - n) mod 26 of v
  function automatic logic [25:0] rotl26(input logic [25:0] v, input logic [4:0] n);
    return (v << n) | (v >> (6'd26 - {1'b0, n}));
  endfunction

  // bit k of the result takes bit (k + n) mod 26 of v
  function automatic logic [25:0] rotr26(input logic [25:0] v, input logic [4:0] n);
    return (v >> n) | (v << (6'd26 - {1'b0, n}));
  endfunction

  assign at_notch  = (pos == NOTCH_POS);
  assign step_en   = step & (ALWAYS_STEP | carry_in | (DOUBLE_STEP & at_notch));
  assign carry_out = step_en & at_notch;

  always_comb begin
    pos_nxt  = pos;
    ring_nxt = ring;
    if (load) begin
      if (load_pos < 5'd26)  pos_nxt  = load_pos;
      if (load_ring < 5'd26) ring_nxt = load_ring;
    end else if (step_en) begin
      pos_nxt = (pos == 5'd25) ? 5'd0 : pos + 5'd1;
    end
    // OFF is registered alongside POS/RING so the rotators never see the subtract
    diff     = {1'b0, pos_nxt} + 6'd26 - {1'b0, ring_nxt};
    diff_mod = (diff >= 6'd26) ? diff - 6'd26 : diff;
    off_nxt  = diff_mod[4:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos  <= 5'd0;
      ring <= 5'd0;
      off  <= 5'd0;
    end else begin
      pos  <= pos_nxt;
      ring <= ring_nxt;
      off  <= off_nxt;
    end
  end

  assign bus.fwd_to_filt = rotl26(bus.fwd_in, off);
  assign bus.inv_to_filt = rotl26(bus.inv_in, off);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.fwd_out       <= 26'd0;
      bus.fwd_valid_out <= 1'b0;
      bus.inv_out       <= 26'd0;
      bus.inv_valid_out <= 1'b0;
    end else begin
      bus.fwd_valid_out <= bus.fwd_valid_in;
      bus.inv_valid_out <= bus.inv_valid_in;
      if (bus.fwd_valid_in) bus.fwd_out <= rotr26(bus.fwd_from_filt, off);
      if (bus.inv_valid_in) bus.inv_out <= rotr26(bus.inv_from_filt, off);
    end
  end

endmodule

// File: tb/tb_rotor_stage.sv
// Directed bench for rotor_stage: a rightmost-rotor instance carries the datapath checks,
// a middle-rotor instance shares the controls to exercise the double step.
module tb_rotor_stage;

  logic       clk;
  logic       rst_n;
  logic       step;
  logic       carry_in;
  logic       load;
  logic [4:0] load_pos;
  logic [4:0] load_ring;
  logic [4:0] pos_a;
  logic       carry_a;
  logic [4:0] pos_m;
  logic       carry_m;
  logic       loop;
  logic [25:0] fwd_man;
  logic [25:0] inv_man;

  int n_cmp;
  int n_err;

  logic [25:0] fwd_exp_q[$];
  logic [25:0] inv_exp_q[$];
  logic [25:0] fe;
  logic [25:0] ie;

  rotor_stage_if bus ();
  rotor_stage_if bus_m ();

  rotor_stage #(.NOTCH(16), .ALWAYS_STEP(1'b1), .DOUBLE_STEP(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .step(step), .carry_in(carry_in), .load(load),
    .load_pos(load_pos), .load_ring(load_ring), .bus(bus.slave),
    .pos(pos_a), .carry_out(carry_a)
  );

  rotor_stage #(.NOTCH(16), .ALWAYS_STEP(1'b0), .DOUBLE_STEP(1'b1)) u_mid (
    .clk(clk), .rst_n(rst_n), .step(step), .carry_in(carry_in), .load(load),
    .load_pos(load_pos), .load_ring(load_ring), .bus(bus_m.slave),
    .pos(pos_m), .carry_out(carry_m)
  );

  // filter stand-in: either a straight loopback or a hand-set vector
  assign bus.fwd_from_filt = loop ? bus.fwd_to_filt : fwd_man;
  assign bus.inv_from_filt = loop ? bus.inv_to_filt : inv_man;

  assign bus_m.fwd_in        = 26'd0;
  assign bus_m.fwd_valid_in  = 1'b0;
  assign bus_m.fwd_from_filt = 26'd0;
  assign bus_m.inv_in        = 26'd0;
  assign bus_m.inv_valid_in  = 1'b0;
  assign bus_m.inv_from_filt = 26'd0;

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && bus.fwd_valid_out) begin
      if (fwd_exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL fwd_out_unexpected: got %0h required none", bus.fwd_out);
      end else begin
        fe = fwd_exp_q.pop_front();
        check("fwd_out", {6'd0, bus.fwd_out}, {6'd0, fe});
      end
    end
    if (rst_n && bus.inv_valid_out) begin
      if (inv_exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL inv_out_unexpected: got %0h required none", bus.inv_out);
      end else begin
        ie = inv_exp_q.pop_front();
        check("inv_out", {6'd0, bus.inv_out}, {6'd0, ie});
      end
    end
  end

  task automatic clear_inputs();
    step = 1'b0; carry_in = 1'b0; load = 1'b0; load_pos = 5'd0; load_ring = 5'd0;
    bus.fwd_in = 26'd0; bus.fwd_valid_in = 1'b0;
    bus.inv_in = 26'd0; bus.inv_valid_in = 1'b0;
    fwd_man = 26'd0; inv_man = 26'd0;
  endtask

  task automatic do_load(input logic [4:0] p, input logic [4:0] r);
    load = 1'b1; load_pos = p; load_ring = r;
    tick();
    load = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    loop  = 1'b1;
    clear_inputs();

    // reset held with random activity
    repeat (3) begin
      tick();
      step = 1'($urandom_range(0, 1)); carry_in = 1'($urandom_range(0, 1));
      load = 1'b1; load_pos = 5'($urandom_range(0, 25)); load_ring = 5'($urandom_range(0, 25));
      bus.fwd_in = 26'($urandom); bus.fwd_valid_in = 1'b1;
      bus.inv_in = 26'($urandom); bus.inv_valid_in = 1'b1;
    end
    @(negedge clk);
    check("rst_pos", {27'd0, pos_a}, 32'd0);
    check("rst_pos_mid", {27'd0, pos_m}, 32'd0);
    check("rst_fwd_out", {6'd0, bus.fwd_out}, 32'd0);
    check("rst_inv_out", {6'd0, bus.inv_out}, 32'd0);
    check("rst_fwd_valid", {31'd0, bus.fwd_valid_out}, 32'd0);
    check("rst_inv_valid", {31'd0, bus.inv_valid_out}, 32'd0);

    tick();
    clear_inputs();
    rst_n = 1'b1;
    tick();
    bus.fwd_in = 26'd1; bus.fwd_valid_in = 1'b1; fwd_exp_q.push_back(26'd1);
    bus.inv_in = 26'd1; bus.inv_valid_in = 1'b1; inv_exp_q.push_back(26'd1);
    @(negedge clk);
    check("post_rst_to_filt", {6'd0, bus.fwd_to_filt}, 32'd1);
    tick();
    bus.fwd_valid_in = 1'b0; bus.inv_valid_in = 1'b0;

    // notch carry and double step
    do_load(5'd16, 5'd0);
    step = 1'b1;
    @(negedge clk);
    check("carry_at_notch", {31'd0, carry_a}, 32'd1);
    check("carry_mid_notch", {31'd0, carry_m}, 32'd1);
    tick();
    step = 1'b0;
    @(negedge clk);
    check("pos_after_notch", {27'd0, pos_a}, 32'd17);
    check("pos_mid_dstep", {27'd0, pos_m}, 32'd17);
    tick();
    step = 1'b1; carry_in = 1'b0;
    @(negedge clk);
    check("carry_mid_off_notch", {31'd0, carry_m}, 32'd0);
    tick();
    step = 1'b0;
    @(negedge clk);
    check("pos_mid_held", {27'd0, pos_m}, 32'd17);
    check("pos_always_step", {27'd0, pos_a}, 32'd18);
    tick();
    step = 1'b1; carry_in = 1'b1;
    tick();
    step = 1'b0; carry_in = 1'b0;
    @(negedge clk);
    check("pos_mid_carry_in", {27'd0, pos_m}, 32'd18);

    // wrap 25 -> 0
    tick();
    do_load(5'd25, 5'd0);
    step = 1'b1;
    @(negedge clk);
    check("carry_at_25", {31'd0, carry_a}, 32'd0);
    tick();
    step = 1'b0;
    @(negedge clk);
    check("pos_wrap", {27'd0, pos_a}, 32'd0);

    // offset 1: entry shifts up, exit shifts back down
    tick();
    do_load(5'd1, 5'd0);
    loop = 1'b0;
    bus.fwd_in = 26'd1; fwd_man = 26'd1 << 1; bus.fwd_valid_in = 1'b1; fwd_exp_q.push_back(26'd1);
    bus.inv_in = 26'd1; inv_man = 26'd1 << 3; bus.inv_valid_in = 1'b1; inv_exp_q.push_back(26'd1 << 2);
    @(negedge clk);
    check("fwd_to_filt_off1", {6'd0, bus.fwd_to_filt}, 32'h2);
    check("inv_to_filt_off1", {6'd0, bus.inv_to_filt}, 32'h2);
    tick();
    bus.fwd_valid_in = 1'b0; bus.inv_valid_in = 1'b0;

    // ring 1: offset 25
    do_load(5'd0, 5'd1);
    bus.fwd_in = 26'd1; fwd_man = 26'd1; bus.fwd_valid_in = 1'b1; fwd_exp_q.push_back(26'd1 << 1);
    @(negedge clk);
    check("fwd_to_filt_ring1", {6'd0, bus.fwd_to_filt}, 32'h0200_0000);
    tick();
    bus.fwd_valid_in = 1'b0;
    @(negedge clk);
    check("fwd_valid_drop", {31'd0, bus.fwd_valid_out}, 32'd1);
    tick();
    @(negedge clk);
    check("fwd_valid_low", {31'd0, bus.fwd_valid_out}, 32'd0);
    check("fwd_out_hold", {6'd0, bus.fwd_out}, 32'h2);

    // load beats step; carry still reflects the step request
    tick();
    do_load(5'd16, 5'd0);
    load = 1'b1; load_pos = 5'd5; load_ring = 5'd0; step = 1'b1;
    @(negedge clk);
    check("carry_with_load", {31'd0, carry_a}, 32'd1);
    tick();
    load = 1'b0; step = 1'b0;
    @(negedge clk);
    check("pos_load_wins", {27'd0, pos_a}, 32'd5);

    // out-of-range fields are ignored individually
    tick();
    do_load(5'd30, 5'd3);
    loop = 1'b1;
    bus.fwd_in = 26'd1; bus.fwd_valid_in = 1'b1; fwd_exp_q.push_back(26'd1);
    @(negedge clk);
    check("pos_bad_field", {27'd0, pos_a}, 32'd5);
    check("to_filt_off2", {6'd0, bus.fwd_to_filt}, 32'h4);
    tick();
    bus.fwd_valid_in = 1'b0;
    do_load(5'd7, 5'd27);
    bus.fwd_in = 26'd1; bus.fwd_valid_in = 1'b1; fwd_exp_q.push_back(26'd1);
    @(negedge clk);
    check("pos_load7", {27'd0, pos_a}, 32'd7);
    check("to_filt_off4", {6'd0, bus.fwd_to_filt}, 32'h10);
    tick();
    bus.fwd_valid_in = 1'b0;
    tick();

    // back-to-back letters, both directions, filter looped
    for (int i = 0; i < 26; i++) begin
      bus.fwd_in = 26'd1 << i;        bus.fwd_valid_in = 1'b1; fwd_exp_q.push_back(26'd1 << i);
      bus.inv_in = 26'd1 << (25 - i); bus.inv_valid_in = 1'b1; inv_exp_q.push_back(26'd1 << (25 - i));
      @(negedge clk);
      if (i > 0) begin
        check("stream_fwd_valid", {31'd0, bus.fwd_valid_out}, 32'd1);
        check("stream_inv_valid", {31'd0, bus.inv_valid_out}, 32'd1);
      end
      tick();
    end
    bus.fwd_valid_in = 1'b0; bus.inv_valid_in = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("fwd_queue_drained", fwd_exp_q.size(), 32'd0);
    check("inv_queue_drained", inv_exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
